// File: rtl/sass_pkg.sv
// Purpose : shared types and constants for the phase-to-sample shaping path.
// Latency : n/a (package only).
// Backpr. : n/a (package only).
package sass_pkg;

  typedef enum logic [1:0] {
    WAVE_SAW    = 2'd0,
    WAVE_SQUARE = 2'd1,
    WAVE_TRI    = 2'd2,
    WAVE_SINE   = 2'd3
  } wave_t;

  localparam logic [7:0] MIDSCALE = 8'h80;
  localparam int         PHASE_W  = 8;

  // Folds the lower 7 phase bits onto one quarter wave: the second quarter
  // runs the table backwards so the sine peak sits at phase 0x40 / 0xC0.
  function automatic logic [5:0] sine_index(input logic [PHASE_W-1:0] p);
    return p[6] ? (6'd63 - p[5:0]) : p[5:0];
  endfunction

endpackage

// File: rtl/sine_quarter_rom.sv
// Purpose : quarter-wave sine magnitude table, round(127*sin(pi*(k+0.5)/128)).
// Latency : combinational.
// Backpr. : none; pure lookup.
// Ports   : k  - table index 0..63
//           q  - sine magnitude 2..127
module sine_quarter_rom #(
  parameter int SINE_BITS = 7
) (
  input  logic [5:0]           k,
  output logic [SINE_BITS-1:0] q
);

  logic [6:0] q7;

  always_comb begin
    q7 = 7'd0;
    case (k)
      6'd0:  q7 = 7'd2;   6'd1:  q7 = 7'd5;   6'd2:  q7 = 7'd8;   6'd3:  q7 = 7'd11;
      6'd4:  q7 = 7'd14;  6'd5:  q7 = 7'd17;  6'd6:  q7 = 7'd20;  6'd7:  q7 = 7'd23;
      6'd8:  q7 = 7'd26;  6'd9:  q7 = 7'd29;  6'd10: q7 = 7'd32;  6'd11: q7 = 7'd35;
      6'd12: q7 = 7'd38;  6'd13: q7 = 7'd41;  6'd14: q7 = 7'd44;  6'd15: q7 = 7'd47;
      6'd16: q7 = 7'd50;  6'd17: q7 = 7'd53;  6'd18: q7 = 7'd56;  6'd19: q7 = 7'd58;
      6'd20: q7 = 7'd61;  6'd21: q7 = 7'd64;  6'd22: q7 = 7'd67;  6'd23: q7 = 7'd69;
      6'd24: q7 = 7'd72;  6'd25: q7 = 7'd74;  6'd26: q7 = 7'd77;  6'd27: q7 = 7'd79;
      6'd28: q7 = 7'd82;  6'd29: q7 = 7'd84;  6'd30: q7 = 7'd86;  6'd31: q7 = 7'd89;
      6'd32: q7 = 7'd91;  6'd33: q7 = 7'd93;  6'd34: q7 = 7'd95;  6'd35: q7 = 7'd97;
      6'd36: q7 = 7'd99;  6'd37: q7 = 7'd101; 6'd38: q7 = 7'd103; 6'd39: q7 = 7'd105;
      6'd40: q7 = 7'd106; 6'd41: q7 = 7'd108; 6'd42: q7 = 7'd110; 6'd43: q7 = 7'd111;
      6'd44: q7 = 7'd113; 6'd45: q7 = 7'd114; 6'd46: q7 = 7'd115; 6'd47: q7 = 7'd117;
      6'd48: q7 = 7'd118; 6'd49: q7 = 7'd119; 6'd50: q7 = 7'd120; 6'd51: q7 = 7'd121;
      6'd52: q7 = 7'd122; 6'd53: q7 = 7'd123; 6'd54: q7 = 7'd124; 6'd55: q7 = 7'd124;
      6'd56: q7 = 7'd125; 6'd57: q7 = 7'd125; 6'd58: q7 = 7'd126; 6'd59: q7 = 7'd126;
      6'd60: q7 = 7'd127; 6'd61: q7 = 7'd127; 6'd62: q7 = 7'd127; 6'd63: q7 = 7'd127;
      default: q7 = 7'd0;
    endcase
  end

  assign q = SINE_BITS'(q7);

endmodule

// File: rtl/wave_shaper.sv
// Purpose : maps divider phase quotient to an 8-bit unsigned sample (saw/square/tri/sine).
// Latency : 2 clocks from phase_done rising to the sample_vld strobe.
// Backpr. : none; accepts a capture every other cycle, one strobe per capture.
// Ports   : clk, RST (sync, active-high) | phase, phase_done (level), wave_sel, duty
//           -> sample_out (held between strobes, midscale 0x80), sample_vld (1-cycle)
module wave_shaper
  import sass_pkg::*;
#(
  parameter int SINE_BITS = 7
) (
  input  logic               clk,
  input  logic               RST,
  input  logic [PHASE_W-1:0] phase,
  input  logic               phase_done,
  input  logic [1:0]         wave_sel,
  input  logic [7:0]         duty,
  output logic [7:0]         sample_out,
  output logic               sample_vld
);

  // ---------------- stage 1: capture on done rising edge ----------------
  logic               done_q;
  logic               first;
  logic               s1_vld;
  logic [PHASE_W-1:0] phase_r;
  logic [7:0]         duty_r;
  wave_t              active_sel;

  logic cap;
  logic wrapped;

  assign cap     = phase_done & ~done_q;
  assign wrapped = (phase < phase_r);

  // done_q resets high so a done level still asserted out of reset is not
  // mistaken for a fresh result. The shape only switches at a phase wrap so
  // a selection change never cuts a waveform period in half.
  always_ff @(posedge clk) begin
    if (RST) begin
      done_q     <= 1'b1;
      first      <= 1'b1;
      s1_vld     <= 1'b0;
      phase_r    <= '0;
      duty_r     <= '0;
      active_sel <= WAVE_SAW;
    end else begin
      done_q <= phase_done;
      s1_vld <= cap;
      if (cap) begin
        phase_r <= phase;
        duty_r  <= duty;
        if (first || wrapped) begin
          active_sel <= wave_t'(wave_sel);
          first      <= 1'b0;
        end
      end
    end
  end

  // ---------------- stage 2: shape and register ----------------
  logic [5:0]           sine_k;
  logic [SINE_BITS-1:0] sine_q;
  logic [8:0]           sine_sum;
  logic [6:0]           tri_t;
  logic [7:0]           shape_dat;

  assign sine_k = sine_index(phase_r);

  sine_quarter_rom #(
    .SINE_BITS(SINE_BITS)
  ) u_sine_rom (
    .k(sine_k),
    .q(sine_q)
  );

  // 128 +/- q stays within 1..255 because q <= 127, so dropping bit 8 is safe.
  always_comb begin
    sine_sum = {1'b0, MIDSCALE};
    if (phase_r[7])
      sine_sum = {1'b0, MIDSCALE} - {{(9-SINE_BITS){1'b0}}, sine_q};
    else
      sine_sum = {1'b0, MIDSCALE} + {{(9-SINE_BITS){1'b0}}, sine_q};
  end

  assign tri_t = phase_r[7] ? ~phase_r[6:0] : phase_r[6:0];

  always_comb begin
    shape_dat = MIDSCALE;
    case (active_sel)
      WAVE_SAW:    shape_dat = phase_r;
      WAVE_SQUARE: shape_dat = (phase_r < duty_r) ? 8'hFF : 8'h00;
      WAVE_TRI:    shape_dat = {tri_t, 1'b0};
      WAVE_SINE:   shape_dat = sine_sum[7:0];
      default:     shape_dat = MIDSCALE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (RST) begin
      sample_out <= MIDSCALE;
      sample_vld <= 1'b0;
    end else begin
      sample_vld <= s1_vld;
      if (s1_vld)
        sample_out <= shape_dat;
    end
  end

endmodule
